trashbin_mem_arbiter: RTL and testbench
=======================================

Name: trashbin_mem_arbiter

Overview:
- Shares the single core memory port (AddressBus / DataReadBus / DataWriteBus / WriteAssert) between two requesters:
  - instruction fetch (F), read-only;
  - load/store unit (D), read or write.
- Sequences each access through a fixed memory wait-state count and returns read data with a one-cycle Done pulse.
- Sits between the core phase sequencer and on-die RAM, replacing the direct ProgramCounter-to-AddressBus connection.

Parameters:
- MEM_LATENCY, 2, cycles the address and control stay on the bus before DataReadBus is valid; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- CoreClock  in  1  core clock; all logic on the rising edge.
- CoreReset  in  1  synchronous, active-high reset.
- F_Req  in  1  fetch request; held until F_Done.
- F_Addr  in  ADDR_W  fetch address; stable while F_Req is high.
- F_Done  out  1  one-cycle pulse; F_RData valid in the same cycle.
- F_RData  out  DATA_W  fetched word.
- D_Req  in  1  data request; held until D_Done.
- D_Write  in  1  1 = store, 0 = load.
- D_Addr  in  ADDR_W  data address.
- D_WData  in  DATA_W  store data.
- D_Done  out  1  one-cycle completion pulse.
- D_RData  out  DATA_W  load result.
- Busy  out  1  high in BUSY and RESP states.
- AddressBus  out  ADDR_W  memory address.
- DataWriteBus  out  DATA_W  memory write data.
- DataReadBus  in  DATA_W  memory read data.
- WriteAssert  out  1  memory write strobe.

Behaviour:
- Reset (synchronous, CoreReset high at an edge):
  - state = IDLE, counter = 0, priority pointer = D;
  - AddressBus = 0, DataWriteBus = 0, WriteAssert = 0;
  - F_Done = D_Done = 0, F_RData = D_RData = 0, Busy = 0.
  - Reset overrides every other event, including mid-access: WriteAssert is low in the cycle after the reset edge, and no Done is ever issued for the aborted access.
- State machine:
  - IDLE:
    - If no Req, stay in IDLE.
    - If one Req, grant it.
    - If both Req, grant D (fixed priority; see Optional Feature).
    - On grant: latch address, write data and write flag (F always read) into bus registers; record the owner; counter = 0; go to BUSY.
  - BUSY:
    - Bus registers are driven unchanged; WriteAssert = latched write flag for every BUSY cycle.
    - Counter increments each cycle.
    - At the edge where counter == MEM_LATENCY-1:
      - read: DataReadBus is captured into the owner's RData register;
      - WriteAssert drops to 0;
      - go to RESP.
  - RESP (exactly one cycle):
    - Owner's Done = 1; the other Done = 0.
    - Req inputs are ignored.
    - Next state is IDLE.
    - The requester must drop Req by the end of the RESP cycle unless it wants another access.
- Outputs in IDLE and RESP: AddressBus holds its last value, DataWriteBus holds its last value, WriteAssert = 0.
- Latency: if Req is high before edge N, then:
  - the bus is driven from edge N;
  - DataReadBus is sampled at edge N+MEM_LATENCY;
  - Done is high in the cycle after edge N+MEM_LATENCY.
- Throughput: MEM_LATENCY+2 cycles per access; one access in flight at most.
- Store: D_RData is unchanged; D_Done still pulses.
- The RData registers of both requesters hold their value until that requester's next read completes.
- Counter width is 4 bits. The counter never wraps within an access and is cleared on every grant.
- A Req raised during BUSY or RESP waits until IDLE. Req dropped mid-access is ignored; the access completes.

Optional Feature:
- Macro: TRASHBIN_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, grant the requester named by the priority pointer. After every grant, the pointer moves to the requester not granted. A single requester is granted regardless of the pointer, and the pointer still updates.
- Undefined: fixed D-over-F priority; the pointer register is not built.

Test Plan:
- MEM_LATENCY=2, F_Req=1, F_Addr=0x10, memory returns 0xDEADBEEF at 0x10 -> AddressBus=0x10 two cycles, F_Done pulse one cycle later with F_RData=0xDEADBEEF, Busy high 3 cycles.
- D store: D_Write=1, D_Addr=0x40, D_WData=0x12345678 -> WriteAssert high exactly 2 cycles with DataWriteBus=0x12345678, D_Done one pulse, D_RData unchanged.
- F_Req and D_Req asserted together and held (macro off) -> D served first, F served next, edges exactly MEM_LATENCY+2 cycles apart; F_Done never coincides with D_Done.
- Macro on, both held continuously for 4 accesses -> grant order D,F,D,F.
- CoreReset pulsed during the first BUSY cycle of a store -> WriteAssert=0 on the next cycle, no D_Done, state IDLE; the held Req is re-granted after reset releases.
- MEM_LATENCY=1, back-to-back F reads 0x0, 0x4 -> F_Done pulses 3 cycles apart, F_RData correct for each.

Source files
------------

// File: rtl/trashbin_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter for the single core memory port.
// Define TRASHBIN_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed D-over-F priority.
module trashbin_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              CoreClock,
  input  logic              CoreReset,
  input  logic              F_Req,
  input  logic [ADDR_W-1:0] F_Addr,
  output logic              F_Done,
  output logic [DATA_W-1:0] F_RData,
  input  logic              D_Req,
  input  logic              D_Write,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D_WData,
  output logic              D_Done,
  output logic [DATA_W-1:0] D_RData,
  output logic              Busy,
  output logic [ADDR_W-1:0] AddressBus,
  output logic [DATA_W-1:0] DataWriteBus,
  input  logic [DATA_W-1:0] DataReadBus,
  output logic              WriteAssert
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             owner_d, owner_n;
  logic             write_q, write_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, frdata_n, drdata_n;
  logic             we_n, fdone_n, ddone_n;
  logic             grant_d;
`ifdef TRASHBIN_ARB_ROUND_ROBIN_EN
  logic             ptr_d, ptr_n;
`endif

  // Next-state and next-output logic; every register's next value is computed here.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    owner_n  = owner_d;
    write_n  = write_q;
    addr_n   = AddressBus;
    wdata_n  = DataWriteBus;
    we_n     = 1'b0;
    fdone_n  = 1'b0;
    ddone_n  = 1'b0;
    frdata_n = F_RData;
    drdata_n = D_RData;
    grant_d  = 1'b0;
`ifdef TRASHBIN_ARB_ROUND_ROBIN_EN
    ptr_n    = ptr_d;
`endif
    case (state)
      S_IDLE: begin
        if (F_Req || D_Req) begin
`ifdef TRASHBIN_ARB_ROUND_ROBIN_EN
          grant_d = D_Req && (!F_Req || ptr_d);
          ptr_n   = !grant_d;
`else
          grant_d = D_Req;
`endif
          owner_n = grant_d;
          write_n = grant_d & D_Write;
          we_n    = grant_d & D_Write;
          addr_n  = grant_d ? D_Addr : F_Addr;
          if (grant_d) wdata_n = D_WData;
          cnt_n   = '0;
          state_n = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_n = cnt + CNT_W'(1);
        we_n  = write_q;
        if (cnt == CNT_LAST) begin
          we_n    = 1'b0;
          fdone_n = !owner_d;
          ddone_n = owner_d;
          if (!write_q) begin
            if (owner_d) drdata_n = DataReadBus;
            else         frdata_n = DataReadBus;
          end
          state_n = S_RESP;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CoreClock) begin
    if (CoreReset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      owner_d      <= 1'b0;
      write_q      <= 1'b0;
      AddressBus   <= '0;
      DataWriteBus <= '0;
      WriteAssert  <= 1'b0;
      F_Done       <= 1'b0;
      D_Done       <= 1'b0;
      F_RData      <= '0;
      D_RData      <= '0;
      Busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      owner_d      <= owner_n;
      write_q      <= write_n;
      AddressBus   <= addr_n;
      DataWriteBus <= wdata_n;
      WriteAssert  <= we_n;
      F_Done       <= fdone_n;
      D_Done       <= ddone_n;
      F_RData      <= frdata_n;
      D_RData      <= drdata_n;
      Busy         <= (state_n != S_IDLE);
    end
  end

`ifdef TRASHBIN_ARB_ROUND_ROBIN_EN
  // Pointer names the requester that wins the next tie; starts at D.
  always_ff @(posedge CoreClock) begin
    if (CoreReset) ptr_d <= 1'b1;
    else           ptr_d <= ptr_n;
  end
`endif

endmodule

// File: tb/tb_trashbin_mem_arbiter.sv
// Directed bench for trashbin_mem_arbiter: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1.
module tb_trashbin_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Instance a: MEM_LATENCY = 2
  logic        f_req, d_req, d_write;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic        f_done, d_done, busy, we;
  logic [31:0] f_rdata, d_rdata, addr, wdata, rdata;

  // Instance b: MEM_LATENCY = 1, fetch only
  logic        b_f_req;
  logic [31:0] b_f_addr;
  logic        b_f_done, b_d_done, b_busy, b_we;
  logic [31:0] b_f_rdata, b_d_rdata, b_addr, b_wdata, b_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ~a;
  endfunction

  assign rdata   = mem_rd(addr);
  assign b_rdata = mem_rd(b_addr);

  trashbin_mem_arbiter #(.MEM_LATENCY(2), .ADDR_W(32), .DATA_W(32)) u_dut (
    .CoreClock(clk), .CoreReset(rst),
    .F_Req(f_req), .F_Addr(f_addr), .F_Done(f_done), .F_RData(f_rdata),
    .D_Req(d_req), .D_Write(d_write), .D_Addr(d_addr), .D_WData(d_wdata),
    .D_Done(d_done), .D_RData(d_rdata), .Busy(busy),
    .AddressBus(addr), .DataWriteBus(wdata), .DataReadBus(rdata), .WriteAssert(we)
  );

  trashbin_mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
    .CoreClock(clk), .CoreReset(rst),
    .F_Req(b_f_req), .F_Addr(b_f_addr), .F_Done(b_f_done), .F_RData(b_f_rdata),
    .D_Req(1'b0), .D_Write(1'b0), .D_Addr(32'h0), .D_WData(32'h0),
    .D_Done(b_d_done), .D_RData(b_d_rdata), .Busy(b_busy),
    .AddressBus(b_addr), .DataWriteBus(b_wdata), .DataReadBus(b_rdata), .WriteAssert(b_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int wa_cnt, done_cnt, fd_cyc, dd_cyc, k, c1, c2;
  logic [31:0] r1, r2;
  logic [3:0] seq, exp_seq;
  logic both;

  initial begin
    f_req = 0; d_req = 0; d_write = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
    b_f_req = 0; b_f_addr = 0;
    do_reset();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_fdone", 32'(f_done), 32'd0);
    check("rst_ddone", 32'(d_done), 32'd0);
    check("rst_frdata", f_rdata, 32'h0);
    check("rst_drdata", d_rdata, 32'h0);

    // Fetch read at 0x10, latency 2
    f_req = 1; f_addr = 32'h10;
    tick();
    check("f1_addr_c1", addr, 32'h10);
    check("f1_busy_c1", 32'(busy), 32'd1);
    check("f1_we_c1", 32'(we), 32'd0);
    check("f1_done_c1", 32'(f_done), 32'd0);
    tick();
    check("f1_addr_c2", addr, 32'h10);
    check("f1_busy_c2", 32'(busy), 32'd1);
    check("f1_done_c2", 32'(f_done), 32'd0);
    tick();
    check("f1_done_c3", 32'(f_done), 32'd1);
    check("f1_ddone_c3", 32'(d_done), 32'd0);
    check("f1_rdata", f_rdata, 32'hDEADBEEF);
    check("f1_busy_c3", 32'(busy), 32'd1);
    f_req = 0;
    tick();
    check("f1_done_c4", 32'(f_done), 32'd0);
    check("f1_busy_c4", 32'(busy), 32'd0);
    check("f1_addr_hold", addr, 32'h10);

    // Store to 0x40
    d_req = 1; d_write = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
    wa_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (we) begin
        wa_cnt++;
        check("st_wdata", wdata, 32'h12345678);
        check("st_addr", addr, 32'h40);
      end
      if (d_done) begin
        done_cnt++;
        d_req = 0;
      end
    end
    check("st_we_cycles", 32'(wa_cnt), 32'd2);
    check("st_done_pulses", 32'(done_cnt), 32'd1);
    check("st_drdata_unch", d_rdata, 32'h0);
    check("st_idle_busy", 32'(busy), 32'd0);
    d_write = 0;

    // Simultaneous requests: D (load 0x30) first, then F (0x20)
    do_reset();
    f_req = 1; f_addr = 32'h20;
    d_req = 1; d_addr = 32'h30;
    fd_cyc = -1; dd_cyc = -1; both = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (f_done && d_done) both = 1;
      if (d_done) begin dd_cyc = i; d_req = 0; end
      if (f_done) begin fd_cyc = i; f_req = 0; end
    end
    check("both_d_cycle", 32'(dd_cyc), 32'd3);
    check("both_f_cycle", 32'(fd_cyc), 32'd7);
    check("both_no_overlap", 32'(both), 32'd0);
    check("both_d_rdata", d_rdata, 32'hFFFFFFCF);
    check("both_f_rdata", f_rdata, 32'hFFFFFFDF);

    // Both held for four accesses
    do_reset();
`ifdef TRASHBIN_ARB_ROUND_ROBIN_EN
    exp_seq = 4'b0101;
`else
    exp_seq = 4'b1111;
`endif
    f_req = 1; d_req = 1; seq = 4'b0; k = 0;
    for (int i = 0; i < 30 && k < 4; i++) begin
      tick();
      if (d_done && k < 4) begin seq[k] = 1'b1; k++; end
      else if (f_done && k < 4) begin seq[k] = 1'b0; k++; end
    end
    f_req = 0; d_req = 0;
    check("rr_count", 32'(k), 32'd4);
    check("rr_order", 32'(seq), 32'(exp_seq));
    tick(); tick();

    // Reset during first BUSY cycle of a store
    d_req = 1; d_write = 1; d_addr = 32'h80; d_wdata = 32'hA5A5A5A5;
    tick();
    check("rs_we_busy", 32'(we), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    check("rs_we_after", 32'(we), 32'd0);
    check("rs_busy_after", 32'(busy), 32'd0);
    check("rs_ddone_after", 32'(d_done), 32'd0);
    tick();
    check("rs_regrant_we", 32'(we), 32'd1);
    check("rs_regrant_busy", 32'(busy), 32'd1);
    check("rs_regrant_addr", addr, 32'h80);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (d_done) begin done_cnt++; d_req = 0; end
    end
    check("rs_done_once", 32'(done_cnt), 32'd1);
    d_write = 0;

    // Latency 1: back-to-back fetches at 0x0 and 0x4
    b_f_req = 1; b_f_addr = 32'h0;
    c1 = -1; c2 = -1; r1 = 0; r2 = 0; k = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (b_f_done) begin
        if (k == 0) begin c1 = i; r1 = b_f_rdata; b_f_addr = 32'h4; end
        else if (k == 1) begin c2 = i; r2 = b_f_rdata; b_f_req = 0; end
        k++;
      end
    end
    check("l1_count", 32'(k), 32'd2);
    check("l1_first_cycle", 32'(c1), 32'd2);
    check("l1_spacing", 32'(c2 - c1), 32'd3);
    check("l1_rdata0", r1, 32'hFFFFFFFF);
    check("l1_rdata4", r2, 32'hFFFFFFFB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
